fp32_to_int_converter: RTL and testbench
========================================

// Module: fp32_to_int_converter
// PURPOSE
//  Decodes a normalized IEEE-754 single-precision word, such as the adder's final_sum, into a signed two's-complement integer.
//  Truncates toward zero and saturates out-of-range values.
//  Sits downstream of the FP adder; operands enter and results leave through valid/ready handshakes.
//  The mantissa is aligned by a 1-bit-per-cycle shifter, so latency depends on the exponent.
// PARAMETERS
//  INT_W  32  result width in bits; supported range 16..32
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  in_valid      in   1      operand_ieee is valid
//  in_ready      out  1      block can accept an operand
//  operand_ieee  in   32     {sign, exp[7:0], frac[22:0]}
//  out_valid     out  1      result and flags are valid
//  out_ready     in   1      consumer takes the result
//  result_int    out  INT_W  signed result
//  invalid       out  1      input was NaN
//  overflow      out  1      result saturated (Inf or |x| too large)
//  inexact       out  1      nonzero fraction bits were discarded
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; result_int=0; all flags=0. Reset mid-operation aborts the operation, no output.
//  FSM states:
//   IDLE: in_ready=1. Accepts when in_valid && in_ready at edge k; registers the operand; next state UNPACK.
//   UNPACK (edge k+1): E=exp-127; mant={1,frac} in a max(24,INT_W)+1-bit register; classify, then load N:
//    exp=255, frac!=0 -> result MIN_INT, invalid=1, N=0.
//    exp=255, frac==0 -> result MAX_INT (+) or MIN_INT (-), overflow=1, N=0.
//    exp=0 or E<0 -> result 0, inexact=(operand[30:0]!=0), N=0.
//    E>=INT_W-1 -> result MIN_INT with overflow=0 iff sign=1, E==INT_W-1, frac==0;
//      otherwise saturate by sign with overflow=1; N=0.
//    Otherwise -> N=|E-23|, direction=left if E>23 else right. Next state SHIFT if N>0, else FINISH.
//   SHIFT: one shift per cycle and N decrements; a 1 shifted out on a right shift sets inexact (sticky).
//    Next state FINISH when N reaches 0.
//   FINISH: negates the magnitude if sign=1; drives result_int and flags; out_valid=1; next state DONE.
//   DONE: result_int and flags held stable while out_ready=0.
//    out_ready=1 -> out_valid=0 at the edge; state IDLE.
//  Latency: out_valid rises at edge k+2+N; N=0 for every special case.
//  Throughput: in_ready=0 in all states except IDLE; no new accept in the cycle a result is consumed.
//  Width: inputs with E<=INT_W-2 produce magnitudes < 2^(INT_W-1), so negation never overflows.
//  Negative zero (0x8000_0000) yields 0 with no flags.
//  in_valid held while in_ready=0 is ignored; operand_ieee is sampled only at the accept edge.
//  No X on outputs after reset; flags are cleared at every accept.
// STRUCTURE
//  fp32_pkg (shared with the adder):
//   BIAS=127, EXP_W=8, FRAC_W=23.
//   typedef struct packed {logic sign; logic [7:0] exp; logic [22:0] frac;} fp32_t.
//   typedef enum {IDLE, UNPACK, SHIFT, FINISH, DONE} cvt_state_t.
//   Class constants for NaN, Inf and zero/denormal detection.
//  Sub-module fp32_classify: combinational class + unbiased exponent from fp32_t; reusable by the adder.
//  Everything else (FSM, shifter, sticky, negate) lives in this module.
// TESTING
//  1. 0x3F80_0000 (1.0) accepted at edge k -> result 1, flags 0; N=23, out_valid at edge k+25.
//  2. 0x4B00_0000 (2^23) -> result 8388608, N=0, out_valid at k+2; 0x4B00_0001 with N=0 -> result 8388609.
//  3. 0xC049_0FDB (-3.14159) -> result 0xFFFF_FFFD (-3), inexact=1.
//  4. 0x4F00_0000 -> 0x7FFF_FFFF, overflow=1; 0xCF00_0000 -> 0x8000_0000, overflow=0;
//     0xFF80_0000 -> 0x8000_0000, overflow=1; 0x7FC0_0000 -> 0x8000_0000, invalid=1.
//  5. 0x3F00_0000 (0.5) and 0x0000_0001 (denormal) -> result 0, inexact=1, out_valid at k+2;
//     0x8000_0000 -> 0, no flags.
//  6. Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0.
//     Then assert rst during SHIFT of case 1 -> out_valid=0, in_ready=1; next operand converts correctly.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions used by the FP adder and the
// float-to-integer converter.
package fp32_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  // Unbiased exponent width: covers -127..+128 with a sign bit to spare.
  localparam int EXP_UW = EXP_W + 2;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = '1;
  localparam logic [EXP_W-1:0] EXP_DENORM  = '0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SHIFT,
    FINISH,
    DONE
  } cvt_state_t;

  typedef enum logic [1:0] {
    FP_ZERO,  // zero or denormal
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational classifier: number class plus unbiased exponent of an fp32
// word. Shared with the adder.
module fp32_classify
  import fp32_pkg::*;
(
  input  fp32_t                    i_op,
  output fp_class_t                o_class,
  output logic signed [EXP_UW-1:0] o_exp
);

  logic w_frac_nz;

  assign w_frac_nz = (i_op.frac != '0);
  assign o_exp     = $signed({2'b00, i_op.exp}) - $signed(EXP_UW'(BIAS));

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    o_class = FP_NORM;
    if (i_op.exp == EXP_SPECIAL) begin
      o_class = w_frac_nz ? FP_NAN : FP_INF;
    end else if (i_op.exp == EXP_DENORM) begin
      o_class = FP_ZERO;
    end
  end

endmodule

// File: rtl/fp32_to_int_converter.sv
// fp32 -> signed integer converter: truncates toward zero, saturates, and
// aligns the mantissa with a 1-bit-per-cycle shifter behind valid/ready.
module fp32_to_int_converter
  import fp32_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      operand_ieee,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] result_int,
  output logic             invalid,
  output logic             overflow,
  output logic             inexact
);

  localparam int MANT_W = ((INT_W > 24) ? INT_W : 24) + 1;
  localparam logic signed [EXP_UW-1:0] E_SAT = EXP_UW'(INT_W - 1);
  localparam logic signed [EXP_UW-1:0] E_MID = EXP_UW'(FRAC_W);
  localparam logic [INT_W-1:0] MAX_INT = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_INT = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [MANT_W-INT_W-1:0] MANT_PAD = '0;

  cvt_state_t r_state, w_state_next;

  fp32_t              r_op;
  logic [MANT_W-1:0]  r_mant;
  logic [4:0]         r_cnt;
  logic               r_dir_left;
  logic               r_bypass;
  logic [INT_W-1:0]   r_result_int;
  logic               r_out_valid;
  logic               r_invalid;
  logic               r_overflow;
  logic               r_inexact;

  fp_class_t                w_class;
  logic signed [EXP_UW-1:0] w_exp;
  logic signed [EXP_UW-1:0] w_diff;
  logic [4:0]               w_shift_n;
  logic                     w_normal;
  logic [INT_W-1:0]         w_mag;
  logic                     w_unused;

  fp32_classify u_classify (
    .i_op    (r_op),
    .o_class (w_class),
    .o_exp   (w_exp)
  );

  // In-range exponents need an alignment of |E-23| toward the binary point.
  assign w_normal  = (w_class == FP_NORM) && (w_exp >= 0) && (w_exp < E_SAT);
  assign w_diff    = (w_exp > E_MID) ? (w_exp - E_MID) : (E_MID - w_exp);
  assign w_shift_n = w_diff[4:0];
  assign w_mag     = r_mant[INT_W-1:0];
  assign w_unused  = ^{r_mant[MANT_W-1:INT_W], w_diff[EXP_UW-1:5]};

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign result_int = r_result_int;
  assign invalid    = r_invalid;
  assign overflow   = r_overflow;
  assign inexact    = r_inexact;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_next = UNPACK;
      UNPACK:  w_state_next = (w_normal && (w_shift_n != '0)) ? SHIFT : FINISH;
      SHIFT:   if (r_cnt == 5'd1) w_state_next = FINISH;
      FINISH:  w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_mant       <= '0;
      r_cnt        <= '0;
      r_dir_left   <= 1'b0;
      r_bypass     <= 1'b0;
      r_result_int <= '0;
      r_out_valid  <= 1'b0;
      r_invalid    <= 1'b0;
      r_overflow   <= 1'b0;
      r_inexact    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= operand_ieee;
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
            r_inexact  <= 1'b0;
          end
        end
        UNPACK: begin
          r_cnt    <= '0;
          r_bypass <= 1'b1;
          if (w_class == FP_NAN) begin
            r_mant    <= {MANT_PAD, MIN_INT};
            r_invalid <= 1'b1;
          end else if (w_class == FP_INF) begin
            r_mant     <= {MANT_PAD, (r_op.sign ? MIN_INT : MAX_INT)};
            r_overflow <= 1'b1;
          end else if ((w_class == FP_ZERO) || (w_exp < 0)) begin
            r_mant    <= '0;
            r_inexact <= ({r_op.exp, r_op.frac} != '0);
          end else if (w_exp >= E_SAT) begin
            // -2^(INT_W-1) is the one value at E == INT_W-1 that fits exactly.
            r_mant     <= {MANT_PAD, (r_op.sign ? MIN_INT : MAX_INT)};
            r_overflow <= !(r_op.sign && (w_exp == E_SAT) && (r_op.frac == '0));
          end else begin
            r_mant     <= {{(MANT_W-FRAC_W-1){1'b0}}, 1'b1, r_op.frac};
            r_dir_left <= (w_exp > E_MID);
            r_cnt      <= w_shift_n;
            r_bypass   <= 1'b0;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_dir_left) begin
            r_mant <= r_mant << 1;
          end else begin
            r_mant <= r_mant >> 1;
            if (r_mant[0]) r_inexact <= 1'b1;
          end
        end
        FINISH: begin
          r_result_int <= (r_op.sign && !r_bypass) ? -w_mag : w_mag;
          r_out_valid  <= 1'b1;
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int_converter.sv
// Directed-vector bench for fp32_to_int_converter: values, flags, latency,
// back-pressure and mid-operation reset.
module tb_fp32_to_int_converter;

  localparam int INT_W = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      operand_ieee;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] result_int;
  logic             invalid;
  logic             overflow;
  logic             inexact;

  int n_tests  = 0;
  int n_failed = 0;

  fp32_to_int_converter #(.INT_W(INT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operand_ieee (operand_ieee),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_int   (result_int),
    .invalid      (invalid),
    .overflow     (overflow),
    .inexact      (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operand at edge k and wait for out_valid; returns cycles after k.
  task automatic issue(input logic [31:0] op, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid     = 1'b1;
    operand_ieee = op;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    operand_ieee = 32'hDEAD_BEEF;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_consume", out_valid, 1'b0);
    check("in_ready_after_consume", in_ready, 1'b1);
  endtask

  task automatic run_case(input string tag, input logic [31:0] op,
                          input logic [31:0] exp_res, input logic exp_inv,
                          input logic exp_ovf, input logic exp_inx, input int exp_lat);
    int lat;
    issue(op, lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_int, exp_res);
    check({tag, "_flags"}, {invalid, overflow, inexact}, {exp_inv, exp_ovf, exp_inx});
    consume();
  endtask

  initial begin
    int  lat;
    logic [31:0] held;
    bit  saw_valid;

    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    operand_ieee = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result_int, 32'h0);
    check("reset_flags", {invalid, overflow, inexact}, 3'b000);
    rst = 1'b0;

    //        tag            operand        result         inv   ovf   inx   latency
    run_case("one",         32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 25);
    run_case("two_pow23",   32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 1'b0, 2);
    run_case("two_pow23p1", 32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1'b0, 2);
    run_case("neg_pi",      32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 24);
    run_case("pos_2p31",    32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2);
    run_case("neg_2p31",    32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2);
    run_case("pos_2p31_nz", 32'h4F00_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2);
    run_case("neg_2p31_nz", 32'hCF00_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2);
    run_case("neg_inf",     32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2);
    run_case("pos_inf",     32'h7F80_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2);
    run_case("qnan",        32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);
    run_case("half",        32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2);
    run_case("denormal",    32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2);
    run_case("neg_zero",    32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2);
    run_case("max_left",    32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, 9);
    run_case("neg_left",    32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 1'b0, 9);
    run_case("d123",        32'h42F6_0000, 32'h0000_007B, 1'b0, 1'b0, 1'b0, 19);

    // Back-pressure: result held in DONE, a waiting operand must not be taken.
    issue(32'h42F6_0000, lat);
    check("hold_latency", 64'(lat), 64'd19);
    held         = result_int;
    in_valid     = 1'b1;
    operand_ieee = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_result", result_int, 32'h0000_007B);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    check("hold_same", result_int, held);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_no_accept", in_ready, 1'b1);
    check("consume_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;

    // Reset while shifting case 1 aborts the conversion.
    @(negedge clk);
    in_valid     = 1'b1;
    operand_ieee = 32'h3F80_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_result", result_int, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_output", saw_valid, 1'b0);
    run_case("after_rst",   32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
